// File: rtl/mic_pkg.sv
// Shared types for the PDM mic streamer: scheduler states, slot sequence and default sync byte.
package mic_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GUARD} sched_state_t;
    typedef enum logic [1:0] {SLOT_SYNC, SLOT_L, SLOT_R} slot_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/pdm_deser.sv
// One PDM channel: MSB-first 8-bit shifter feeding a single-entry byte buffer.
module pdm_deser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shift_en,
    input  logic       bit_in,
    input  logic       clear,
    input  logic       take,
    output logic [7:0] byte_out,
    output logic       valid,
    output logic       drop
);
    logic [6:0] shreg;
    logic [2:0] bit_cnt;
    logic       done;

    assign done = shift_en && (bit_cnt == 3'd7);
    // A byte finishing while the buffer is being read is accepted, not dropped.
    assign drop = done && valid && !take && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_out <= '0;
            valid    <= 1'b0;
        end else if (clear) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_out <= '0;
            valid    <= 1'b0;
        end else begin
            if (shift_en) begin
                shreg   <= {shreg[5:0], bit_in};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (done && (!valid || take)) begin
                byte_out <= {shreg, bit_in};
                valid    <= 1'b1;
            end else if (take) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mic_stream_scheduler.sv
// Stereo PDM mic clocking/capture with ordered L,R byte scheduling and periodic sync bytes
// onto the AVR serial TX byte interface.
module mic_stream_scheduler
    import mic_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 16,
    parameter int unsigned SYNC_PERIOD = 64,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       mic_clk,
    input  logic       pdm_in,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    input  logic       tx_block,
    output logic       overflow,
    output logic       active
);
    localparam int DW = $clog2(HALF_PERIOD);
    localparam int PW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] PAIR_LAST = PW'(SYNC_PERIOD - 1);
    localparam slot_t FIRST_SLOT = (SYNC_PERIOD != 0) ? SLOT_SYNC : SLOT_L;

    logic          pdm_meta, pdm_sync;
    logic [DW-1:0] div_cnt;
    logic          tc, shift_l, shift_r;
    logic [7:0]    l_byte, r_byte;
    logic          l_valid, r_valid, l_drop, r_drop;
    logic          take_l, take_r, ready, grant;
    logic [PW-1:0] pair_cnt;
    slot_t         slot;
    sched_state_t  state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdm_meta <= 1'b0;
            pdm_sync <= 1'b0;
        end else begin
            pdm_meta <= pdm_in;
            pdm_sync <= pdm_meta;
        end
    end

    assign tc = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            mic_clk <= 1'b0;
            active  <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            mic_clk <= 1'b0;
            active  <= 1'b0;
        end else begin
            active <= 1'b1;
            if (tc) begin
                div_cnt <= '0;
                mic_clk <= ~mic_clk;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // Left samples at the end of the high phase, right at the end of the low phase.
    assign shift_l = enable && tc && mic_clk;
    assign shift_r = enable && tc && !mic_clk;

    pdm_deser u_deser_l (
        .clk(clk), .rst_n(rst_n), .shift_en(shift_l), .bit_in(pdm_sync), .clear(!enable),
        .take(take_l), .byte_out(l_byte), .valid(l_valid), .drop(l_drop)
    );

    pdm_deser u_deser_r (
        .clk(clk), .rst_n(rst_n), .shift_en(shift_r), .bit_in(pdm_sync), .clear(!enable),
        .take(take_r), .byte_out(r_byte), .valid(r_valid), .drop(r_drop)
    );

    always_comb begin
        state_nxt   = state;
        new_tx_data = 1'b0;
        ready       = 1'b0;
        grant       = 1'b0;
        take_l      = 1'b0;
        take_r      = 1'b0;
        case (slot)
            SLOT_SYNC: ready = 1'b1;
            SLOT_L:    ready = l_valid;
            SLOT_R:    ready = r_valid;
            default:   ready = 1'b0;
        endcase
        case (state)
            ST_IDLE: begin
                grant = enable && !tx_busy && !tx_block && ready;
                if (grant) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                new_tx_data = 1'b1;
                take_l      = (slot == SLOT_L);
                take_r      = (slot == SLOT_R);
                state_nxt   = ST_GUARD;
            end
            ST_GUARD: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data <= '0;
        end else if (grant) begin
            case (slot)
                SLOT_L:  tx_data <= l_byte;
                SLOT_R:  tx_data <= r_byte;
                default: tx_data <= SYNC_BYTE;
            endcase
        end
    end

    // The pointer still names the issued slot during ISSUE, and advances as it leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot     <= FIRST_SLOT;
            pair_cnt <= '0;
        end else if (!enable) begin
            slot     <= FIRST_SLOT;
            pair_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            case (slot)
                SLOT_SYNC: slot <= SLOT_L;
                SLOT_L:    slot <= SLOT_R;
                default: begin
                    if (SYNC_PERIOD != 0 && pair_cnt == PAIR_LAST) begin
                        pair_cnt <= '0;
                        slot     <= SLOT_SYNC;
                    end else begin
                        pair_cnt <= pair_cnt + PW'(1);
                        slot     <= SLOT_L;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                overflow <= 1'b0;
        else if (!enable)          overflow <= 1'b0;
        else if (l_drop || r_drop) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_mic_stream_scheduler.sv
// Randomised bench: drives PDM bits per mic_clk phase, predicts byte stream from sync/pair arithmetic.
module tb_mic_stream_scheduler;
    localparam int SP = 2;

    logic       clk = 1'b0;
    logic       rst_n, enable, mic_clk, pdm_in;
    logic [7:0] tx_data;
    logic       new_tx_data, tx_busy, tx_block, overflow, active;

    int n_chk = 0, n_fail = 0;
    int k = 0, cyc = 0, last_cyc = 0, nb_l = 0, nb_r = 0, k_mark = 0, c = 0;
    logic [7:0] cur_l, cur_r, last_tx;
    logic [7:0] expq_l[$], expq_r[$], log_q[$];
    bit use_pat = 1'b0, rand_busy = 1'b0, found;

    mic_stream_scheduler #(.HALF_PERIOD(16), .SYNC_PERIOD(SP), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mic_clk(mic_clk), .pdm_in(pdm_in),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy), .tx_block(tx_block),
        .overflow(overflow), .active(active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Next bit for a channel; a byte value is chosen at its first bit and queued at its last.
    task automatic drive_bit(input bit is_l);
        if (is_l) begin
            if (nb_l == 0) cur_l = use_pat ? 8'hB3 : 8'($urandom);
            pdm_in = cur_l[7-nb_l];
            nb_l++;
            if (nb_l == 8) begin expq_l.push_back(cur_l); nb_l = 0; end
        end else begin
            if (nb_r == 0) cur_r = use_pat ? 8'h55 : 8'($urandom);
            pdm_in = cur_r[7-nb_r];
            nb_r++;
            if (nb_r == 8) begin expq_r.push_back(cur_r); nb_r = 0; end
        end
    endtask

    // After a rise the next sample is left (at the fall); after a fall it is right.
    initial begin
        pdm_in = 1'b0;
        forever begin
            @(mic_clk);
            #1;
            drive_bit(mic_clk === 1'b1);
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rand_busy) tx_busy = 1'($urandom_range(0, 1));
    end

    // Scoreboard: strobe k after enable is sync when k mod (2*SP+1) is 0, else L (odd) / R (even).
    always @(posedge clk) begin
        #1;
        cyc++;
        if (new_tx_data === 1'b1) begin
            if (k > 0) chk("strobe_gap", 32'(cyc - last_cyc >= 2), 1);
            last_cyc = cyc;
            last_tx  = tx_data;
            log_q.push_back(tx_data);
            if (k % (2*SP+1) == 0) begin
                chk("sync_byte", tx_data, 8'hA5);
            end else if ((k % (2*SP+1)) % 2 == 1) begin
                chk("l_avail", 32'(expq_l.size() > 0), 1);
                if (expq_l.size() > 0) chk("l_byte", tx_data, expq_l.pop_front());
            end else begin
                chk("r_avail", 32'(expq_r.size() > 0), 1);
                if (expq_r.size() > 0) chk("r_byte", tx_data, expq_r.pop_front());
            end
            k++;
        end
    end

    task automatic restart();
        nb_l = 0; nb_r = 0; k = 0;
        expq_l.delete(); expq_r.delete(); log_q.delete();
        drive_bit(1'b0);
        enable = 1'b1;
    endtask

    task automatic wait_k(input int target, input int budget, input string tag);
        int n = 0;
        while (k < target && n < budget) begin @(posedge clk); #2; n++; end
        chk(tag, k, target);
    endtask

    task automatic wait_rise(output int cnt);
        logic p;
        cnt = 0;
        p = mic_clk;
        forever begin
            @(posedge clk); #2; cnt++;
            if (!p && mic_clk) break;
            p = mic_clk;
            if (cnt > 200) begin chk("mic_rise_timeout", 0, 1); break; end
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; tx_busy = 1'b0; tx_block = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mic_clk", mic_clk, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_strobe", new_tx_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_active", active, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Fixed L/R pattern first, then random bytes with a randomly busy transmitter.
        use_pat = 1'b1;
        restart();
        wait_rise(c);
        wait_rise(c);
        chk("mic_period", c, 32);
        chk("active_on", active, 1);
        wait_k(3, 1000, "first_pair_timeout");
        if (log_q.size() >= 3) begin
            chk("first_sync", log_q[0], 8'hA5);
            chk("pat_l", log_q[1], 8'hB3);
            chk("pat_r", log_q[2], 8'h55);
        end
        use_pat = 1'b0;
        rand_busy = 1'b1;
        wait_k(13, 3000, "stream_timeout");
        if (log_q.size() >= 11) begin
            chk("resync_5", log_q[5], 8'hA5);
            chk("resync_10", log_q[10], 8'hA5);
        end
        rand_busy = 1'b0;
        tx_busy = 1'b0;

        // Hold off the transmitter long enough to overrun both channel buffers.
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("ovf_cleared_idle", overflow, 0);
        tx_block = 1'b1;
        restart();
        for (int i = 0; i < 20; i++) wait_rise(c);
        repeat (4) @(posedge clk);
        #2;
        chk("ovf_set", overflow, 1);
        chk("blocked_no_strobe", k, 0);
        while (expq_l.size() > 1) void'(expq_l.pop_back());
        while (expq_r.size() > 1) void'(expq_r.pop_back());
        tx_block = 1'b0;
        wait_k(3, 100, "unblock_timeout");
        chk("ovf_sticky", overflow, 1);

        // Drop enable in the cycle after a strobe.
        found = 1'b0;
        for (int n = 0; n < 1500 && !found; n++) begin
            @(posedge clk); #2;
            if (new_tx_data === 1'b1 && k >= 4) found = 1'b1;
        end
        chk("guard_found", 32'(found), 1);
        @(posedge clk); #2;
        enable = 1'b0;
        @(posedge clk); #2;
        chk("stop_mic_clk", mic_clk, 0);
        chk("stop_active", active, 0);
        chk("stop_overflow", overflow, 0);
        k_mark = k;
        repeat (600) @(posedge clk);
        #2;
        chk("stop_no_strobe", k, k_mark);

        restart();
        wait_k(1, 50, "restart_timeout");
        chk("restart_sync", last_tx, 8'hA5);
        wait_k(3, 1000, "restart_pair_timeout");

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_mic_clk", mic_clk, 0);
        chk("arst_tx_data", tx_data, 0);
        chk("arst_strobe", new_tx_data, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_active", active, 0);
        k_mark = k;
        repeat (100) @(posedge clk);
        #2;
        chk("arst_no_strobe", k, k_mark);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
